// File: rtl/rob_commit_reader.sv
// In-order retire side of the reorder buffer: head/tail/occupancy, allocation grant and
// registered architectural commit, with a timed flush on an exception at head.
// Optional ROB_COMMIT_CNT_EN adds a 32-bit count of non-exception retires (commit_cnt).
module rob_commit_reader #(
    parameter int ADDR_WIDTH     = 3,
    parameter int REG_ADDR_WIDTH = 3,
    parameter int DATA_WIDTH     = 16,
    parameter int FLUSH_CYCLES   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      alloc_req,
    output logic                      alloc_grant,
    output logic [ADDR_WIDTH-1:0]     alloc_addr,
    output logic [ADDR_WIDTH-1:0]     rd_addr,
    input  logic                      rd_done,
    input  logic                      rd_exc,
    input  logic                      rd_has_dest,
    input  logic [REG_ADDR_WIDTH-1:0] rd_dest,
    input  logic [DATA_WIDTH-1:0]     rd_value,
    input  logic                      commit_stall,
    output logic                      clr_we,
    output logic [ADDR_WIDTH-1:0]     clr_addr,
    output logic                      commit_we,
    output logic [REG_ADDR_WIDTH-1:0] commit_dest,
    output logic [DATA_WIDTH-1:0]     commit_value,
    output logic                      flush,
`ifdef ROB_COMMIT_CNT_EN
    output logic [31:0]               commit_cnt,
`endif
    output logic [ADDR_WIDTH:0]       count
);

    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t                    state, state_n;
    logic [ADDR_WIDTH-1:0]     head, head_n;
    logic [ADDR_WIDTH-1:0]     tail, tail_n;
    logic [ADDR_WIDTH:0]       count_n;
    logic [FCW-1:0]            fcnt, fcnt_n;
    logic                      commit_we_n;
    logic [REG_ADDR_WIDTH-1:0] commit_dest_n;
    logic [DATA_WIDTH-1:0]     commit_value_n;
    logic                      ret;

    // Head entry is only trusted when the ROB is non-empty; a stale done bit is ignored.
    assign ret         = (state == ST_RUN) && (count != '0) && rd_done && !commit_stall;
    // Grant looks at the current count, so a full ROB refuses even if it retires this cycle.
    assign alloc_grant = alloc_req && (count != FULL_COUNT) && (state == ST_RUN);
    assign alloc_addr  = tail;
    assign rd_addr     = head;
    assign clr_addr    = head;
    assign clr_we      = ret;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_n        = state;
        head_n         = head;
        tail_n         = tail;
        count_n        = count;
        fcnt_n         = fcnt;
        commit_we_n    = 1'b0;
        commit_dest_n  = commit_dest;
        commit_value_n = commit_value;

        case (state)
            ST_RUN: begin
                if (alloc_grant) begin
                    tail_n = tail + 1'b1;
                end
                if (ret) begin
                    if (rd_exc) begin
                        state_n = ST_FLUSH;
                        fcnt_n  = FCW'(FLUSH_CYCLES - 1);
                    end else begin
                        commit_we_n    = rd_has_dest;
                        commit_dest_n  = rd_dest;
                        commit_value_n = rd_value;
                        head_n         = head + 1'b1;
                    end
                end
                if (alloc_grant && !ret) begin
                    count_n = count + 1'b1;
                end else if (ret && !alloc_grant) begin
                    count_n = count - 1'b1;
                end
            end
            ST_FLUSH: begin
                if (fcnt == '0) begin
                    state_n = ST_RUN;
                    head_n  = '0;
                    tail_n  = '0;
                    count_n = '0;
                end else begin
                    fcnt_n = fcnt - 1'b1;
                end
            end
            default: state_n = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state        <= ST_RUN;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            fcnt         <= '0;
            commit_we    <= 1'b0;
            commit_dest  <= '0;
            commit_value <= '0;
            flush        <= 1'b0;
        end else begin
            state        <= state_n;
            head         <= head_n;
            tail         <= tail_n;
            count        <= count_n;
            fcnt         <= fcnt_n;
            commit_we    <= commit_we_n;
            commit_dest  <= commit_dest_n;
            commit_value <= commit_value_n;
            flush        <= (state_n == ST_FLUSH);
        end
    end

`ifdef ROB_COMMIT_CNT_EN
    // Survives flushes on purpose: it counts architecturally visible retires only.
    always_ff @(posedge clk) begin
        if (reset) begin
            commit_cnt <= '0;
        end else if (ret && !rd_exc) begin
            commit_cnt <= commit_cnt + 1'b1;
        end
    end
`else
    // No retire counter in this build.
`endif

endmodule

// File: tb/tb_rob_commit_reader.sv
// Directed self-checking bench for rob_commit_reader: allocation, retire, stall, wrap,
// exception flush and reset during flush. Outputs are sampled 1 time unit after the edge.
module tb_rob_commit_reader;

    logic        clk;
    logic        reset;
    logic        alloc_req;
    logic        alloc_grant;
    logic [2:0]  alloc_addr;
    logic [2:0]  rd_addr;
    logic        rd_done;
    logic        rd_exc;
    logic        rd_has_dest;
    logic [2:0]  rd_dest;
    logic [15:0] rd_value;
    logic        commit_stall;
    logic        clr_we;
    logic [2:0]  clr_addr;
    logic        commit_we;
    logic [2:0]  commit_dest;
    logic [15:0] commit_value;
    logic        flush;
    logic [3:0]  count;
`ifdef ROB_COMMIT_CNT_EN
    logic [31:0] commit_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    rob_commit_reader #(
        .ADDR_WIDTH(3), .REG_ADDR_WIDTH(3), .DATA_WIDTH(16), .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk), .reset(reset),
        .alloc_req(alloc_req), .alloc_grant(alloc_grant), .alloc_addr(alloc_addr),
        .rd_addr(rd_addr), .rd_done(rd_done), .rd_exc(rd_exc),
        .rd_has_dest(rd_has_dest), .rd_dest(rd_dest), .rd_value(rd_value),
        .commit_stall(commit_stall), .clr_we(clr_we), .clr_addr(clr_addr),
        .commit_we(commit_we), .commit_dest(commit_dest), .commit_value(commit_value),
        .flush(flush),
`ifdef ROB_COMMIT_CNT_EN
        .commit_cnt(commit_cnt),
`endif
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req    = 1'b0;
        rd_done      = 1'b0;
        rd_exc       = 1'b0;
        rd_has_dest  = 1'b0;
        rd_dest      = '0;
        rd_value     = '0;
        commit_stall = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        do_reset();

        // 1: reset state, fill to full, ninth request refused
        check("rst_count", count, 0);
        check("rst_flush", flush, 0);
        check("rst_commit_we", commit_we, 0);
        check("rst_commit_dest", commit_dest, 0);
        check("rst_commit_value", commit_value, 0);
        check("rst_rd_addr", rd_addr, 0);
        for (int i = 0; i < 8; i++) begin
            alloc_req = 1'b1;
            #1;
            check($sformatf("fill_grant%0d", i), alloc_grant, 1);
            check($sformatf("fill_addr%0d", i), alloc_addr, i);
            tick();
        end
        check("full_count", count, 8);
        check("full_grant", alloc_grant, 0);
        check("full_head", rd_addr, 0);
        alloc_req = 1'b0;

        // 2: fill 3, retire head 0
        do_reset();
        alloc_req = 1'b1;
        repeat (3) tick();
        alloc_req   = 1'b0;
        rd_done     = 1'b1;
        rd_has_dest = 1'b1;
        rd_dest     = 3'd5;
        rd_value    = 16'h00AB;
        #1;
        check("ret_clr_we", clr_we, 1);
        check("ret_clr_addr", clr_addr, 0);
        tick();
        idle();
        check("ret_commit_we", commit_we, 1);
        check("ret_commit_dest", commit_dest, 5);
        check("ret_commit_value", commit_value, 16'h00AB);
        check("ret_count", count, 2);
        check("ret_rd_addr", rd_addr, 1);
        tick();
        check("idle_commit_we", commit_we, 0);
        check("idle_dest_hold", commit_dest, 5);
        check("idle_value_hold", commit_value, 16'h00AB);

        // 5: stall blocks retire, release retires
        rd_done      = 1'b1;
        rd_has_dest  = 1'b1;
        rd_dest      = 3'd3;
        rd_value     = 16'h1234;
        commit_stall = 1'b1;
        #1;
        check("stall_clr_we", clr_we, 0);
        tick();
        check("stall_commit_we", commit_we, 0);
        check("stall_head", rd_addr, 1);
        check("stall_count", count, 2);
        commit_stall = 1'b0;
        #1;
        check("release_clr_we", clr_we, 1);
        tick();
        check("release_commit_we", commit_we, 1);
        check("release_dest", commit_dest, 3);
        check("release_value", commit_value, 16'h1234);
        check("release_head", rd_addr, 2);
        check("release_count", count, 1);
        // retire without destination: no write, data path still captures the entry
        rd_has_dest = 1'b0;
        rd_dest     = 3'd6;
        rd_value    = 16'hBEEF;
        tick();
        check("nodest_commit_we", commit_we, 0);
        check("nodest_dest", commit_dest, 6);
        check("nodest_count", count, 0);
        check("nodest_head", rd_addr, 3);
        // empty: stale done ignored
        #1;
        check("empty_clr_we", clr_we, 0);
        tick();
        check("empty_count", count, 0);
        check("empty_head", rd_addr, 3);
        check("empty_commit_we", commit_we, 0);
        idle();

        // 3: move head/tail to 7 with a full ROB, then alloc+ret
        alloc_req = 1'b1;
        repeat (4) tick();
        alloc_req = 1'b0;
        rd_done   = 1'b1;
        repeat (4) tick();
        rd_done   = 1'b0;
        check("wrap_pre_empty", count, 0);
        alloc_req = 1'b1;
        repeat (8) tick();
        check("wrap_full_count", count, 8);
        check("wrap_head7", rd_addr, 7);
        check("wrap_tail7", alloc_addr, 7);
        rd_done     = 1'b1;
        rd_has_dest = 1'b1;
        rd_dest     = 3'd2;
        rd_value    = 16'h0777;
        #1;
        check("full_ret_grant", alloc_grant, 0);
        check("full_ret_clr_we", clr_we, 1);
        tick();
        check("full_ret_count", count, 7);
        check("full_ret_commit_we", commit_we, 1);
        check("full_ret_head_wrap", rd_addr, 0);
        check("full_ret_tail", alloc_addr, 7);
        #1;
        check("both_grant", alloc_grant, 1);
        check("both_addr", alloc_addr, 7);
        tick();
        check("both_count", count, 7);
        check("both_tail_wrap", alloc_addr, 0);
        check("both_head", rd_addr, 1);
`ifdef ROB_COMMIT_CNT_EN
        check("cnt_before_exc", commit_cnt, 9);
`endif

        // 4: exception at head -> 2-cycle flush
        alloc_req   = 1'b0;
        rd_done     = 1'b1;
        rd_exc      = 1'b1;
        rd_has_dest = 1'b1;
        rd_dest     = 3'd4;
        rd_value    = 16'h4444;
        tick();
        idle();
        alloc_req = 1'b1;
        check("exc_commit_we", commit_we, 0);
        check("exc_flush1", flush, 1);
        check("exc_dest_hold", commit_dest, 2);
        check("exc_value_hold", commit_value, 16'h0777);
        check("exc_grant1", alloc_grant, 0);
        tick();
        check("exc_flush2", flush, 1);
        check("exc_grant2", alloc_grant, 0);
        check("exc_commit_we2", commit_we, 0);
        tick();
        check("post_flush", flush, 0);
        check("post_count", count, 0);
        check("post_head", rd_addr, 0);
        check("post_tail", alloc_addr, 0);
        check("post_grant", alloc_grant, 1);
`ifdef ROB_COMMIT_CNT_EN
        check("cnt_after_flush", commit_cnt, 9);
`endif
        alloc_req = 1'b0;

        // 6: reset during first flush cycle
        alloc_req = 1'b1;
        repeat (2) tick();
        alloc_req = 1'b0;
        check("pre6_count", count, 2);
        rd_done = 1'b1;
        rd_exc  = 1'b1;
        tick();
        check("r6_flush", flush, 1);
        idle();
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        alloc_req = 1'b1;
        #1;
        check("r6_flush_cleared", flush, 0);
        check("r6_count", count, 0);
        check("r6_grant", alloc_grant, 1);
        tick();
        check("r6_count_after", count, 1);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
